alu_muldiv_seq: RTL and testbench

- Multi-cycle sequencer that implements unsigned multiply and divide by iterating the shared ALU's ADD and SUB operations.
- Fills the MUL/DIV opcode slots, which currently return zero.
- Sits beside the ALU in the execute stage and drives the ALU's opcode and operand inputs while busy.
- Exposes a valid/ready request/response handshake to the execute controller.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_muldiv_seq.sv | 135 +++++++++++++
 tb/tb_alu_muldiv_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Opcodes and state/operation types shared by the ALU and the multiply/divide
// sequencer that sits beside it in the execute stage.
package alu_pkg;

    localparam logic [4:0] ALU_OP_ADD = 5'd0;
    localparam logic [4:0] ALU_OP_SUB = 5'd1;
    localparam logic [4:0] ALU_OP_MUL = 5'd2;
    localparam logic [4:0] ALU_OP_DIV = 5'd3;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } seq_state_t;

    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } muldiv_op_t;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Unsigned multiply (shift-add) and divide (restoring) sequencer that borrows
// the shared ALU's ADD/SUB, one iteration per cycle, with valid/ready handshakes.
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_op,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_hi,
    output logic [N-1:0] rsp_lo,
    output logic         rsp_dbz,
    output logic         busy,
    output logic [4:0]   alu_op,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic         alu_cin,
    input  logic [N-1:0] alu_out,
    input  logic         alu_c
);

    localparam int CW = $clog2(N + 1);

    seq_state_t    state;
    logic [N-1:0]  acc_hi;
    logic [N-1:0]  acc_lo;
    logic [N-1:0]  b_reg;
    logic [CW-1:0] counter;

    logic [N-1:0]  shifted;
    logic          take;
    logic [N-1:0]  next_hi;
    logic [N-1:0]  next_lo;

    assign alu_cin = 1'b0;

    // ALU drive and the next accumulator value are a function of the current
    // state only, so the ALU result returns within the same iteration cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        alu_op  = ALU_OP_ADD;
        alu_a   = '0;
        alu_b   = '0;
        next_hi = acc_hi;
        next_lo = acc_lo;
        shifted = {acc_hi[N-2:0], acc_lo[N-1]};
        take    = acc_hi[N-1] | alu_c;
        case (state)
            MUL: begin
                alu_a = acc_hi;
                alu_b = b_reg;
                if (acc_lo[0]) {next_hi, next_lo} = {alu_c, alu_out, acc_lo[N-1:1]};
                else           {next_hi, next_lo} = {1'b0, acc_hi, acc_lo[N-1:1]};
            end
            DIV: begin
                alu_op  = ALU_OP_SUB;
                alu_a   = shifted;
                alu_b   = b_reg;
                // A set bit shifted out of acc_hi means the remainder already exceeds b.
                next_hi = take ? alu_out : shifted;
                next_lo = {acc_lo[N-2:0], take};
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_dbz   <= 1'b0;
            busy      <= 1'b0;
            rsp_hi    <= '0;
            rsp_lo    <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            b_reg     <= '0;
            counter   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        if (req_op == MD_DIV && req_b == '0) begin
                            rsp_lo    <= '1;
                            rsp_hi    <= req_a;
                            rsp_dbz   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            acc_hi  <= '0;
                            acc_lo  <= req_a;
                            b_reg   <= req_b;
                            counter <= CW'(N);
                            busy    <= 1'b1;
                            state   <= (req_op == MD_DIV) ? DIV : MUL;
                        end
                    end
                end
                MUL, DIV: begin
                    acc_hi  <= next_hi;
                    acc_lo  <= next_lo;
                    counter <= counter - CW'(1);
                    if (counter == CW'(1)) begin
                        rsp_hi    <= next_hi;
                        rsp_lo    <= next_lo;
                        rsp_dbz   <= 1'b0;
                        rsp_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench: behavioural ALU beside the sequencer, results compared
// against plain integer multiply/divide.
module tb_alu_muldiv_seq;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_op;
    logic [N-1:0] req_a;
    logic [N-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_hi;
    logic [N-1:0] rsp_lo;
    logic         rsp_dbz;
    logic         busy;
    logic [4:0]   alu_op;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic         alu_cin;
    logic [N-1:0] alu_out;
    logic         alu_c;

    int checks = 0;
    int errors = 0;
    logic watch_sub = 1'b0;
    logic saw_sub   = 1'b0;

    always #5 clk = ~clk;

    alu_muldiv_seq #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_hi    (rsp_hi),
        .rsp_lo    (rsp_lo),
        .rsp_dbz   (rsp_dbz),
        .busy      (busy),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_out   (alu_out),
        .alu_c     (alu_c)
    );

    // Behavioural ALU: ADD returns the carry-out, SUB returns the no-borrow flag.
    always_comb begin
        alu_out = '0;
        alu_c   = 1'b0;
        case (alu_op)
            5'd0: {alu_c, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            5'd1: begin
                alu_out = alu_a - alu_b;
                alu_c   = (alu_a >= alu_b);
            end
            default: ;
        endcase
    end

    always @(negedge clk) if (watch_sub && alu_op == 5'd1) saw_sub = 1'b1;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_dbz"},   32'(rsp_dbz),   32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_rsp_hi"},    32'(rsp_hi),    32'd0);
        check({tag, "_rsp_lo"},    32'(rsp_lo),    32'd0);
        check({tag, "_alu_op"},    32'(alu_op),    32'd0);
        check({tag, "_alu_a"},     32'(alu_a),     32'd0);
        check({tag, "_alu_b"},     32'(alu_b),     32'd0);
        check({tag, "_alu_cin"},   32'(alu_cin),   32'd0);
    endtask

    // Called at a negedge in IDLE; returns at the negedge of cycle 1.
    task automatic issue(input logic op, input logic [N-1:0] a, input logic [N-1:0] b);
        check("accept_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
    endtask

    task automatic wait_rsp(input string tag, input int exp_lat);
        int lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_rsp(input string tag, input logic op, input logic [N-1:0] a, input logic [N-1:0] b);
        int unsigned ea, eb, prod;
        logic [N-1:0] exp_hi, exp_lo;
        logic exp_dbz;
        ea = a;
        eb = b;
        exp_dbz = 1'b0;
        if (op == 1'b0) begin
            prod   = ea * eb;
            exp_hi = N'(prod / 256);
            exp_lo = N'(prod % 256);
        end else if (eb == 0) begin
            exp_hi  = a;
            exp_lo  = 8'hFF;
            exp_dbz = 1'b1;
        end else begin
            exp_hi = N'(ea % eb);
            exp_lo = N'(ea / eb);
        end
        check({tag, "_hi"},  32'(rsp_hi),  32'(exp_hi));
        check({tag, "_lo"},  32'(rsp_lo),  32'(exp_lo));
        check({tag, "_dbz"}, 32'(rsp_dbz), 32'(exp_dbz));
    endtask

    task automatic release_rsp(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_valid_cleared"}, 32'(rsp_valid), 32'd0);
        check({tag, "_ready_back"},    32'(req_ready), 32'd1);
    endtask

    task automatic run(input string tag, input logic op, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] b_copy = b;
        issue(op, a, b);
        wait_rsp(tag, (op == 1'b1 && b_copy == '0) ? 1 : N + 1);
        check_rsp(tag, op, a, b);
        release_rsp(tag);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run("mul_13x11",  1'b0, 8'd13,  8'd11);
        run("mul_255x255", 1'b0, 8'd255, 8'd255);
        run("div_200_7",  1'b1, 8'd200, 8'd7);
        run("div_255_1",  1'b1, 8'd255, 8'd1);
        run("div_80_c0",  1'b1, 8'h80,  8'hC0);

        // Divide by zero must answer in one cycle without touching the subtractor.
        saw_sub   = 1'b0;
        watch_sub = 1'b1;
        run("div_by_zero", 1'b1, 8'h5A, 8'h00);
        watch_sub = 1'b0;
        check("dbz_no_sub", 32'(saw_sub), 32'd0);

        // Backpressure: response held while rsp_ready stays low; new requests ignored.
        issue(1'b0, 8'd3, 8'd4);
        wait_rsp("bp", N + 1);
        req_valid = 1'b1;
        req_op    = 1'b1;
        req_a     = 8'hAA;
        req_b     = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_hi",    32'(rsp_hi),    32'h00);
            check("bp_hold_lo",    32'(rsp_lo),    32'h0C);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        release_rsp("bp");
        run("b2b_div", 1'b1, 8'd100, 8'd9);

        // Reset in the middle of a multiply.
        issue(1'b0, 8'd77, 8'd5);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N + 3; i++) begin
            @(negedge clk);
            check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        run("after_rst", 1'b0, 8'd77, 8'd5);

        // Random operations against integer arithmetic, with occasional zero divisors.
        for (int i = 0; i < 24; i++) begin
            logic         op;
            logic [N-1:0] a, b;
            op = 1'($urandom_range(0, 1));
            a  = N'($urandom);
            b  = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
            run($sformatf("rand%0d", i), op, a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
